// File: rtl/axi4_lite_pkg.sv
// Shared types for the AXI4-Lite register slave: response codes and FSM states.
package axi4_lite_pkg;

   typedef enum logic [1:0] {
      OKAY   = 2'b00,
      SLVERR = 2'b10
   } resp_t;

   typedef enum logic {
      W_IDLE,
      W_RESP
   } wstate_t;

   typedef enum logic {
      R_IDLE,
      R_DATA
   } rstate_t;

endpackage

// File: rtl/axi4_lite_strb_merge.sv
// Byte-strobe merge: each strobed byte takes the new write data, others keep the old value.
module axi4_lite_strb_merge #(
   parameter int DATA = 32
) (
   input  logic [DATA-1:0]   i_old,
   input  logic [DATA-1:0]   i_wdata,
   input  logic [DATA/8-1:0] i_wstrb,
   output logic [DATA-1:0]   o_new
);

   always_comb begin
      o_new = i_old;
      for (int i = 0; i < DATA / 8; i++) begin
         if (i_wstrb[i]) o_new[i*8 +: 8] = i_wdata[i*8 +: 8];
      end
   end

endmodule

// File: rtl/axi4_lite_slave_regs.sv
// AXI4-Lite slave exposing NUM_REGS 32-bit registers with independent read/write FSMs.
// Optional AxPROT[0] privilege check enabled by defining AXI4_LITE_SLAVE_PROT_CHECK_EN.
module axi4_lite_slave_regs
   import axi4_lite_pkg::*;
#(
   parameter int ADDR     = 32,
   parameter int DATA     = 32,
   parameter int NUM_REGS = 8
) (
   input  logic                     system_clock,
   input  logic                     reset,
   input  logic                     AWVALID,
   output logic                     AWREADY,
   input  logic [ADDR-1:0]          AWADDR,
   input  logic [1:0]               AWPROT,
   input  logic                     WVALID,
   output logic                     WREADY,
   input  logic [DATA-1:0]          WDATA,
   input  logic [DATA/8-1:0]        WSTRB,
   output logic                     BVALID,
   input  logic                     BREADY,
   output logic [1:0]               BRESP,
   input  logic                     ARVALID,
   output logic                     ARREADY,
   input  logic [ADDR-1:0]          ARADDR,
   input  logic [1:0]               ARPROT,
   output logic                     RVALID,
   input  logic                     RREADY,
   output logic [DATA-1:0]          RDATA,
   output logic [1:0]               RRESP,
   output logic [NUM_REGS*DATA-1:0] regs_o
);

   localparam int IDX_W = $clog2(NUM_REGS);

   wstate_t           r_wstate, w_wstate_nxt;
   rstate_t           r_rstate, w_rstate_nxt;
   logic              r_aw_held, r_w_held;
   logic [ADDR-1:0]   r_awaddr;
   logic              r_aw_prot0;
   logic [DATA-1:0]   r_wdata;
   logic [DATA/8-1:0] r_wstrb;
   resp_t             r_bresp, r_rresp;
   logic [DATA-1:0]   r_rdata;
   logic [DATA-1:0]   r_regs [NUM_REGS];

   logic              w_aw_hs, w_w_hs, w_ar_hs, w_do_write;
   logic              w_wr_err, w_rd_err;
   logic [IDX_W-1:0]  w_widx, w_ridx;
   logic [DATA-1:0]   w_merged;
   logic              w_unused;

   assign w_aw_hs    = AWVALID & AWREADY;
   assign w_w_hs     = WVALID & WREADY;
   assign w_ar_hs    = ARVALID & ARREADY;
   assign w_do_write = (r_wstate == W_IDLE) & r_aw_held & r_w_held;
   assign w_widx     = r_awaddr[2 +: IDX_W];
   assign w_ridx     = ARADDR[2 +: IDX_W];

   // Any address bit above the register window makes the access out of range.
`ifdef AXI4_LITE_SLAVE_PROT_CHECK_EN
   assign w_wr_err = (|(r_awaddr >> (IDX_W + 2))) | ~r_aw_prot0;
   assign w_rd_err = (|(ARADDR >> (IDX_W + 2))) | ~ARPROT[0];
   assign w_unused = ^{AWPROT[1], ARPROT[1], r_awaddr[1:0], ARADDR[1:0]};
`else
   assign w_wr_err = |(r_awaddr >> (IDX_W + 2));
   assign w_rd_err = |(ARADDR >> (IDX_W + 2));
   assign w_unused = ^{AWPROT[1], ARPROT, r_aw_prot0, r_awaddr[1:0], ARADDR[1:0]};
`endif

   axi4_lite_strb_merge #(
      .DATA (DATA)
   ) u_strb_merge (
      .i_old   (r_regs[w_widx]),
      .i_wdata (r_wdata),
      .i_wstrb (r_wstrb),
      .o_new   (w_merged)
   );

   always_ff @(posedge system_clock) begin
      if (reset) begin
         r_wstate <= W_IDLE;
         r_rstate <= R_IDLE;
      end else begin
         r_wstate <= w_wstate_nxt;
         r_rstate <= w_rstate_nxt;
      end
   end

   always_comb begin
      w_wstate_nxt = r_wstate;
      unique case (r_wstate)
         W_IDLE: if (r_aw_held && r_w_held) w_wstate_nxt = W_RESP;
         W_RESP: if (BREADY) w_wstate_nxt = W_IDLE;
      endcase
      w_rstate_nxt = r_rstate;
      unique case (r_rstate)
         R_IDLE: if (ARVALID) w_rstate_nxt = R_DATA;
         R_DATA: if (RREADY) w_rstate_nxt = R_IDLE;
      endcase
   end

   always_comb begin
      AWREADY = (r_wstate == W_IDLE) && !r_aw_held;
      WREADY  = (r_wstate == W_IDLE) && !r_w_held;
      BVALID  = (r_wstate == W_RESP);
      BRESP   = r_bresp;
      ARREADY = (r_rstate == R_IDLE);
      RVALID  = (r_rstate == R_DATA);
      RDATA   = r_rdata;
      RRESP   = r_rresp;
   end

   always_ff @(posedge system_clock) begin
      if (reset) begin
         r_aw_held  <= 1'b0;
         r_w_held   <= 1'b0;
         r_awaddr   <= '0;
         r_aw_prot0 <= 1'b0;
         r_wdata    <= '0;
         r_wstrb    <= '0;
         r_bresp    <= OKAY;
         r_rdata    <= '0;
         r_rresp    <= OKAY;
         for (int k = 0; k < NUM_REGS; k++) r_regs[k] <= '0;
      end else begin
         if (w_aw_hs) begin
            r_aw_held  <= 1'b1;
            r_awaddr   <= AWADDR;
            r_aw_prot0 <= AWPROT[0];
         end
         if (w_w_hs) begin
            r_w_held <= 1'b1;
            r_wdata  <= WDATA;
            r_wstrb  <= WSTRB;
         end
         if (w_do_write) begin
            r_bresp <= w_wr_err ? SLVERR : OKAY;
            if (!w_wr_err) r_regs[w_widx] <= w_merged;
         end
         if ((r_wstate == W_RESP) && BREADY) begin
            r_aw_held <= 1'b0;
            r_w_held  <= 1'b0;
         end
         // Reads sample r_regs before any same-edge write lands.
         if (w_ar_hs) begin
            r_rdata <= w_rd_err ? '0 : r_regs[w_ridx];
            r_rresp <= w_rd_err ? SLVERR : OKAY;
         end
      end
   end

   for (genvar k = 0; k < NUM_REGS; k++) begin : g_regs_o
      assign regs_o[k*DATA +: DATA] = r_regs[k];
   end

endmodule

// File: tb/tb_axi4_lite_slave_regs.sv
// Directed self-checking bench for axi4_lite_slave_regs (default build, 8 x 32-bit registers).
module tb_axi4_lite_slave_regs;

   logic         clk = 1'b0;
   logic         reset;
   logic         awvalid, wvalid, bready, arvalid, rready;
   logic         awready, wready, bvalid, arready, rvalid;
   logic [31:0]  awaddr, araddr, wdata, rdata;
   logic [1:0]   awprot, arprot, bresp, rresp;
   logic [3:0]   wstrb;
   logic [255:0] regs;
   logic [31:0]  em [8];
   int           total = 0;
   int           bad   = 0;

   always #5 clk = ~clk;

   axi4_lite_slave_regs #(
      .ADDR     (32),
      .DATA     (32),
      .NUM_REGS (8)
   ) dut (
      .system_clock (clk),
      .reset        (reset),
      .AWVALID      (awvalid),
      .AWREADY      (awready),
      .AWADDR       (awaddr),
      .AWPROT       (awprot),
      .WVALID       (wvalid),
      .WREADY       (wready),
      .WDATA        (wdata),
      .WSTRB        (wstrb),
      .BVALID       (bvalid),
      .BREADY       (bready),
      .BRESP        (bresp),
      .ARVALID      (arvalid),
      .ARREADY      (arready),
      .ARADDR       (araddr),
      .ARPROT       (arprot),
      .RVALID       (rvalid),
      .RREADY       (rready),
      .RDATA        (rdata),
      .RRESP        (rresp),
      .regs_o       (regs)
   );

   task automatic tick();
      @(negedge clk);
   endtask

   task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
      total++;
      assert (obs === exp)
      else begin
         bad++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [255:0] model();
      logic [255:0] v;
      for (int k = 0; k < 8; k++) v[k*32 +: 32] = em[k];
      return v;
   endfunction

   // AW and W presented together; response accepted after checking.
   task automatic wr(input string tag, input logic [31:0] a, input logic [31:0] d,
                     input logic [3:0] s, input logic [1:0] exp_resp);
      awvalid = 1'b1; awaddr = a; wvalid = 1'b1; wdata = d; wstrb = s;
      tick();
      awvalid = 1'b0; wvalid = 1'b0;
      chk({tag, ".rdy_lo"}, {awready, wready, bvalid}, 3'b000);
      tick();
      chk({tag, ".bvalid"}, bvalid, 1'b1);
      chk({tag, ".bresp"}, bresp, exp_resp);
      chk({tag, ".regs"}, regs, model());
      bready = 1'b1;
      tick();
      bready = 1'b0;
      chk({tag, ".idle"}, {bvalid, awready, wready}, 3'b011);
   endtask

   task automatic rd(input string tag, input logic [31:0] a, input logic [31:0] exp_d,
                     input logic [1:0] exp_resp);
      arvalid = 1'b1; araddr = a;
      tick();
      arvalid = 1'b0;
      chk({tag, ".rvalid"}, {rvalid, arready}, 2'b10);
      chk({tag, ".rdata"}, rdata, exp_d);
      chk({tag, ".rresp"}, rresp, exp_resp);
      rready = 1'b1;
      tick();
      rready = 1'b0;
      chk({tag, ".idle"}, {rvalid, arready}, 2'b01);
   endtask

   initial begin
      for (int k = 0; k < 8; k++) em[k] = 32'h0;
      reset = 1'b1;
      awvalid = 1'b0; wvalid = 1'b0; bready = 1'b0; arvalid = 1'b0; rready = 1'b0;
      awaddr = '0; araddr = '0; wdata = '0; wstrb = '0; awprot = 2'b00; arprot = 2'b00;
      tick(); tick();
      chk("rst.ready", {awready, wready, arready}, 3'b111);
      chk("rst.valid", {bvalid, rvalid}, 2'b00);
      chk("rst.resp", {bresp, rresp, rdata}, 36'h0);
      chk("rst.regs", regs, 256'h0);
      reset = 1'b0;
      tick();

      em[1] = 32'hDEADBEEF;
      wr("w_together", 32'h4, 32'hDEADBEEF, 4'hF, 2'b00);
      rd("r_0x4", 32'h4, 32'hDEADBEEF, 2'b00);

      // W leads AW by three cycles, partial strobe on a preloaded register.
      em[2] = 32'hAABBCCDD;
      wr("w_preload", 32'h8, 32'hAABBCCDD, 4'hF, 2'b00);
      wvalid = 1'b1; wdata = 32'h11223344; wstrb = 4'b0101;
      tick();
      wvalid = 1'b0;
      chk("w_first.rdy", {wready, awready, bvalid}, 3'b010);
      tick(); tick();
      awvalid = 1'b1; awaddr = 32'h8;
      tick();
      awvalid = 1'b0;
      chk("w_first.wait", {awready, bvalid}, 2'b00);
      tick();
      em[2] = 32'hAA22CC44;
      chk("w_first.bvalid", {bvalid, bresp}, 3'b100);
      chk("w_first.regs", regs, model());
      bready = 1'b1; tick(); bready = 1'b0;

      wr("w_oor", 32'h20, 32'hFFFFFFFF, 4'hF, 2'b10);
      rd("r_oor", 32'h20, 32'h0, 2'b10);
      wr("w_strb0", 32'h4, 32'h01020304, 4'h0, 2'b00);
      rd("r_strb0", 32'h4, 32'hDEADBEEF, 2'b00);

      // Backpressure on B then on R.
      awvalid = 1'b1; awaddr = 32'hC; wvalid = 1'b1; wdata = 32'h12345678; wstrb = 4'hF;
      tick();
      awvalid = 1'b0; wvalid = 1'b0;
      tick();
      em[3] = 32'h12345678;
      for (int i = 0; i < 5; i++) begin
         chk("bp_b.hold", {bvalid, bresp, awready, wready}, 5'b10000);
         tick();
      end
      chk("bp_b.regs", regs, model());
      bready = 1'b1; tick(); bready = 1'b0;
      chk("bp_b.release", {bvalid, awready, wready}, 3'b011);
      arvalid = 1'b1; araddr = 32'hC;
      tick();
      arvalid = 1'b0;
      for (int i = 0; i < 4; i++) begin
         chk("bp_r.hold", {rvalid, arready, rresp, rdata}, {2'b10, 2'b00, 32'h12345678});
         tick();
      end
      rready = 1'b1; tick(); rready = 1'b0;

      // Read sampled on the same edge as the write update sees the old value.
      awvalid = 1'b1; awaddr = 32'h0; wvalid = 1'b1; wdata = 32'h55; wstrb = 4'hF;
      tick();
      awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b1; araddr = 32'h0;
      tick();
      arvalid = 1'b0;
      em[0] = 32'h55;
      chk("race.b", {bvalid, bresp}, 3'b100);
      chk("race.r", {rvalid, rresp, rdata}, {1'b1, 2'b00, 32'h0});
      chk("race.regs", regs, model());
      bready = 1'b1; rready = 1'b1; tick(); bready = 1'b0; rready = 1'b0;
      rd("race.after", 32'h0, 32'h55, 2'b00);

      // Reset with both a B and an R response pending.
      awvalid = 1'b1; awaddr = 32'h10; wvalid = 1'b1; wdata = 32'h99; wstrb = 4'hF;
      arvalid = 1'b1; araddr = 32'h4;
      tick();
      awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
      tick();
      chk("mid.pending", {bvalid, rvalid}, 2'b11);
      reset = 1'b1;
      tick();
      reset = 1'b0;
      for (int k = 0; k < 8; k++) em[k] = 32'h0;
      chk("mid.valid", {bvalid, rvalid, awready, wready, arready}, 5'b00111);
      chk("mid.regs", regs, 256'h0);
      chk("mid.rdata", rdata, 32'h0);

      // A W captured before reset must be forgotten.
      wvalid = 1'b1; wdata = 32'hCAFEF00D; wstrb = 4'hF;
      tick();
      wvalid = 1'b0; reset = 1'b1;
      tick();
      reset = 1'b0;
      awvalid = 1'b1; awaddr = 32'h4;
      tick();
      awvalid = 1'b0;
      tick(); tick();
      chk("abort.nob", {bvalid, wready, awready}, 3'b010);
      em[1] = 32'h0000BEEF;
      wvalid = 1'b1; wdata = 32'h0000BEEF; wstrb = 4'h3;
      tick();
      wvalid = 1'b0;
      tick();
      chk("abort.b", {bvalid, bresp}, 3'b100);
      chk("abort.regs", regs, model());
      bready = 1'b1; tick(); bready = 1'b0;

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL timeout: observed=running expected=finished");
      $fatal(1, "timeout");
   end

endmodule
